// File: rtl/data_ram_hs.sv
// Handshaked byte-lane data memory: one load/store per cycle, registered read
// path, response backpressure and out-of-range error reporting.
module data_ram_hs #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int DEPTH_LOG2 = 17
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W/8-1:0] req_sel,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                rsp_we
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF   = $clog2(NB);
    localparam int HI_LO = DEPTH_LOG2 + OFF;
    localparam int DEPTH = 2 ** DEPTH_LOG2;

    generate
        if (HI_LO > ADDR_W || DATA_W < 8 || (DATA_W % 8) != 0 || (1 << OFF) != NB) begin : g_bad_params
            $error("data_ram_hs: illegal DATA_W/ADDR_W/DEPTH_LOG2 combination");
        end
    endgenerate

    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;
    logic                  rsp_we_q,    rsp_we_d;

    logic                  accept;
    logic                  addr_err;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [NB-1:0]         lane_we;
    logic [DATA_W-1:0]     rd_word;

    assign word_idx = req_addr[HI_LO-1:OFF];

    // Address bits above the word index must be zero; with no such bits the
    // check disappears entirely.
    generate
        if (HI_LO == ADDR_W) begin : g_no_hi
            assign addr_err = 1'b0;
        end else begin : g_hi
            assign addr_err = |req_addr[ADDR_W-1:HI_LO];
        end
        if (OFF > 0) begin : g_low
            logic unused_low_bits;
            assign unused_low_bits = ^req_addr[OFF-1:0];
        end
    endgenerate

    assign req_ready = !rst && (!rsp_valid_q || rsp_ready);
    assign accept    = req_valid && req_ready;
    assign lane_we   = (accept && req_we && !addr_err) ? req_sel : '0;

    generate
        for (genvar i = 0; i < NB; i++) begin : g_lane
            logic [7:0] mem [DEPTH];

            always_ff @(posedge clk) begin
                if (lane_we[i]) begin
                    mem[word_idx] <= req_wdata[8*i +: 8];
                end
            end

            assign rd_word[8*i +: 8] = mem[word_idx];
        end
    endgenerate

    // A new accept overwrites the response register even while the old one
    // retires in the same edge, giving one response per cycle.
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_we_d    = rsp_we_q;
        if (accept) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = addr_err;
            rsp_we_d    = req_we;
            rsp_rdata_d = (req_we || addr_err) ? '0 : rd_word;
        end else if (rsp_valid_q && rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_we_q    <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_we_q    <= rsp_we_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_we    = rsp_we_q;

endmodule
